// File: rtl/tpu_chess_pkg.sv
// Shared chess/TPU definitions: square encodings, board type and the
// evaluation-dispatcher state enum.
package tpu_chess_pkg;

  localparam int BOARD_W = 8;
  localparam int BOARD_H = 8;
  localparam int SQ_W    = 8;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    KING   = 3'd1,
    QUEEN  = 3'd2,
    ROOK   = 3'd3,
    KNIGHT = 3'd4,
    BISHOP = 3'd5,
    PAWN   = 3'd6
  } piece_e;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } colour_e;

  typedef logic [BOARD_H-1:0][BOARD_W-1:0][SQ_W-1:0] board_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } disp_state_e;

  // Square layout: bit 3 = colour, bits 2:0 = piece.
  function automatic logic [SQ_W-1:0] make_square(colour_e c, piece_e p);
    return {{(SQ_W-4){1'b0}}, c, p};
  endfunction

endpackage

// File: rtl/board_fifo.sv
// DEPTH-entry synchronous FIFO with registered occupancy; DEPTH must be a
// power of two so the pointers wrap naturally.
module board_fifo #(
  parameter int ENTRY_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count carry
  // state that matters, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/eval_dispatcher.sv
// Feeds candidate boards to the evaluator one at a time and tracks the best
// score per batch. Optional WAIT watchdog enabled by EVAL_TIMEOUT_EN.
module eval_dispatcher
  import tpu_chess_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_W      = 12,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                           clk,
  input  logic                                           nrst,
  input  logic                                           cand_iv,
  output logic                                           cand_ir,
  input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]   cand_id,
  input  logic [TAG_W-1:0]                               cand_tag,
  input  logic                                           cand_last,
  input  logic                                           maximize,
  output logic                                           grid_ov,
  output logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]   grid_od,
  input  logic                                           dnn_iv,
  input  logic signed [DATA_WIDTH-1:0]                   dnn_id,
  output logic                                           best_ov,
  output logic [TAG_W-1:0]                               best_tag,
  output logic signed [DATA_WIDTH-1:0]                   best_score,
  output logic [CNT_W-1:0]                               best_count,
  output logic                                           busy,
  output logic                                           timeout_err
);

  localparam int BOARD_BITS = HEIGHT * WIDTH * DATA_WIDTH;
  localparam int ENTRY_W    = BOARD_BITS + TAG_W + 1;

  disp_state_e                   state;
  logic [ENTRY_W-1:0]            head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [$clog2(DEPTH):0]        fifo_count;
  logic                          unused_count;

  logic [TAG_W-1:0]              tag_l;
  logic                          last_l;
  logic                          max_l;
  logic                          batch_open;
  logic                          have_score;
  logic [TAG_W-1:0]              held_tag;
  logic signed [DATA_WIDTH-1:0]  held_score;
  logic [CNT_W-1:0]              held_count;

  logic                          score_evt;
  logic                          abandon;
  logic                          wait_done;
  logic                          go_issue;
  logic                          take;
  logic [TAG_W-1:0]              nxt_tag;
  logic signed [DATA_WIDTH-1:0]  nxt_score;
  logic [CNT_W-1:0]              nxt_count;

  board_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (cand_iv),
    .push_data ({cand_id, cand_tag, cand_last}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_count = ^fifo_count;
  assign cand_ir      = !fifo_full;
  assign fifo_pop     = (state == S_ISSUE);
  assign busy         = (state != S_IDLE) || !fifo_empty;
  assign score_evt    = (state == S_WAIT) && dnn_iv;
  assign wait_done    = score_evt || abandon;
  // Issue straight from WAIT on a non-last result so there is no IDLE bubble.
  assign go_issue     = !fifo_empty &&
                        ((state == S_IDLE) || ((state == S_WAIT) && wait_done && !last_l));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    take      = 1'b0;
    nxt_tag   = held_tag;
    nxt_score = held_score;
    nxt_count = held_count;
    if (score_evt) begin
      take = !have_score || (max_l ? (dnn_id > held_score) : (dnn_id < held_score));
    end
    if (take) begin
      nxt_tag   = tag_l;
      nxt_score = dnn_id;
    end
    if (wait_done && (held_count != '1)) nxt_count = held_count + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      grid_ov    <= 1'b0;
      grid_od    <= '0;
      best_ov    <= 1'b0;
      best_tag   <= '0;
      best_score <= '0;
      best_count <= '0;
      tag_l      <= '0;
      last_l     <= 1'b0;
      max_l      <= 1'b0;
      batch_open <= 1'b0;
      have_score <= 1'b0;
      held_tag   <= '0;
      held_score <= '0;
      held_count <= '0;
    end else begin
      grid_ov <= 1'b0;
      best_ov <= 1'b0;
      case (state)
        S_IDLE: if (!fifo_empty) state <= S_ISSUE;
        S_ISSUE: begin
          if (!batch_open) begin
            max_l      <= maximize;
            batch_open <= 1'b1;
          end
          state <= S_WAIT;
        end
        S_WAIT: if (wait_done) begin
          held_tag   <= nxt_tag;
          held_score <= nxt_score;
          held_count <= nxt_count;
          have_score <= have_score || score_evt;
          if (last_l) begin
            state      <= S_DONE;
            best_ov    <= 1'b1;
            best_tag   <= nxt_tag;
            best_score <= nxt_score;
            best_count <= nxt_count;
          end else if (!fifo_empty) begin
            state <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          held_tag   <= '0;
          held_score <= '0;
          held_count <= '0;
          have_score <= 1'b0;
          batch_open <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
      if (go_issue) begin
        grid_ov <= 1'b1;
        grid_od <= head[ENTRY_W-1 -: BOARD_BITS];
        tag_l   <= head[TAG_W:1];
        last_l  <= head[0];
      end
    end
  end

`ifdef EVAL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign abandon = (state == S_WAIT) && !dnn_iv && (wd_cnt == WD_W'(TIMEOUT - 1));

  // timeout_err holds through the batch's best_ov (DONE) cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !dnn_iv) wd_cnt <= wd_cnt + 1'b1;
      else                              wd_cnt <= '0;
      if (abandon)                timeout_err <= 1'b1;
      else if (state == S_DONE)   timeout_err <= 1'b0;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign abandon        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
